// File: rtl/pipeline_trace_monitor.sv
// pipeline_trace_monitor: samples the rv32i_cpu debug outputs every RUN cycle
// into a circular trace buffer, counts stall/bubble/branch events, stops on
// halt (ECALL/EBREAK in execute) or on cycle-budget timeout, then drains the
// buffer oldest-first over a valid/ready port.
// Optional build macro TRACE_FILTER_EN: when defined, RUN cycles with a stall
// or an execute bubble are not recorded (counters and stop detection unchanged).
module pipeline_trace_monitor #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [XLEN-1:0]  dbg_pc_f,
  input  logic [XLEN-1:0]  dbg_instr_e,
  input  logic [XLEN-1:0]  dbg_result_e,
  input  logic             dbg_stall,
  input  logic             dbg_bubble_ex,
  input  logic             dbg_branch_taken,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [XLEN-1:0]  rd_pc,
  output logic [XLEN-1:0]  rd_instr,
  output logic [XLEN-1:0]  rd_result,
  output logic [CNT_W-1:0] rd_cycle,
  output logic [3:0]       rd_flags,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] branch_count,
  output logic             halted,
  output logic             timeout,
  output logic             overflow,
  output logic             done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0]  INSTR_ECALL  = XLEN'(32'h0000_0073);
  localparam logic [XLEN-1:0]  INSTR_EBREAK = XLEN'(32'h0010_0073);
  localparam logic [OCC_W-1:0] OCC_FULL     = OCC_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d, branch_q, branch_d;
  logic             halted_q, halted_d, timeout_q, timeout_d;
  logic             overflow_q, overflow_d;

  logic [XLEN-1:0]  mem_pc_q     [DEPTH];
  logic [XLEN-1:0]  mem_instr_q  [DEPTH];
  logic [XLEN-1:0]  mem_result_q [DEPTH];
  logic [CNT_W-1:0] mem_cycle_q  [DEPTH];
  logic [3:0]       mem_flags_q  [DEPTH];

  logic             halt_det, timeout_hit, wr_en, rd_xfer;
  logic [CNT_W:0]   cycle_next_wide;
  logic [3:0]       wr_flags;

  // Halt only counts for a real instruction in execute, never a bubble.
  assign halt_det = !dbg_bubble_ex &&
                    ((dbg_instr_e == INSTR_ECALL) || (dbg_instr_e == INSTR_EBREAK));
  // One extra bit so a saturated cycle counter still compares correctly.
  assign cycle_next_wide = {1'b0, cycle_q} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit     = !halt_det && (cycle_next_wide >= {1'b0, max_cycles});
  assign wr_flags        = {halt_det, dbg_branch_taken, dbg_bubble_ex, dbg_stall};
  assign rd_xfer         = rd_valid && rd_ready;

`ifdef TRACE_FILTER_EN
  assign wr_en = (state_q == S_RUN) && !dbg_stall && !dbg_bubble_ex;
`else
  assign wr_en = (state_q == S_RUN);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN:   if (halt_det || timeout_hit) state_d = S_DRAIN;
      S_DRAIN: if (count_d == '0) state_d = S_DONE;
      S_DONE:  if (clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: the record port shows zeros unless a record is offered.
  always_comb begin
    rd_valid  = (state_q == S_DRAIN) && (count_q != '0);
    done      = (state_q == S_DONE);
    rd_pc     = '0;
    rd_instr  = '0;
    rd_result = '0;
    rd_cycle  = '0;
    rd_flags  = '0;
    if (rd_valid) begin
      rd_pc     = mem_pc_q[rd_ptr_q];
      rd_instr  = mem_instr_q[rd_ptr_q];
      rd_result = mem_result_q[rd_ptr_q];
      rd_cycle  = mem_cycle_q[rd_ptr_q];
      rd_flags  = mem_flags_q[rd_ptr_q];
    end
  end

  // Pointer, occupancy, counter and sticky-flag updates.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cycle_d    = cycle_q;
    stall_d    = stall_q;
    bubble_d   = bubble_q;
    branch_d   = branch_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    case (state_q)
      S_RUN: begin
        cycle_d = sat_inc(cycle_q);
        if (dbg_stall)        stall_d  = sat_inc(stall_q);
        if (dbg_bubble_ex)    bubble_d = sat_inc(bubble_q);
        if (dbg_branch_taken) branch_d = sat_inc(branch_q);
        if (halt_det)         halted_d  = 1'b1;
        else if (timeout_hit) timeout_d = 1'b1;
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (count_q == OCC_FULL) begin
            // Full: the new record replaces the oldest one.
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + OCC_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (rd_xfer) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - OCC_W'(1);
        end
      end
      S_DONE: begin
        if (clear) begin
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          cycle_d    = '0;
          stall_d    = '0;
          bubble_d   = '0;
          branch_d   = '0;
          halted_d   = 1'b0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      stall_q    <= '0;
      bubble_q   <= '0;
      branch_q   <= '0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
      branch_q   <= branch_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  // Trace storage write; data only, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc_q[wr_ptr_q]     <= dbg_pc_f;
      mem_instr_q[wr_ptr_q]  <= dbg_instr_e;
      mem_result_q[wr_ptr_q] <= dbg_result_e;
      mem_cycle_q[wr_ptr_q]  <= cycle_q;
      mem_flags_q[wr_ptr_q]  <= wr_flags;
    end
  end

  assign cycle_count  = cycle_q;
  assign stall_count  = stall_q;
  assign bubble_count = bubble_q;
  assign branch_count = branch_q;
  assign halted       = halted_q;
  assign timeout      = timeout_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Testbench for pipeline_trace_monitor: table-driven scenarios, hand-written
// corner sequences and randomized runs against a queue-based reference model.
module tb_pipeline_trace_monitor;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst, enable, clear;
  logic [CNT_W-1:0] max_cycles;
  logic [XLEN-1:0]  dbg_pc_f, dbg_instr_e, dbg_result_e;
  logic             dbg_stall, dbg_bubble_ex, dbg_branch_taken;
  logic             rd_valid, rd_ready;
  logic [XLEN-1:0]  rd_pc, rd_instr, rd_result;
  logic [CNT_W-1:0] rd_cycle;
  logic [3:0]       rd_flags;
  logic [CNT_W-1:0] cycle_count, stall_count, bubble_count, branch_count;
  logic             halted, timeout, overflow, done;

  always #5 clk = ~clk;

  pipeline_trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .max_cycles(max_cycles),
    .dbg_pc_f(dbg_pc_f), .dbg_instr_e(dbg_instr_e), .dbg_result_e(dbg_result_e),
    .dbg_stall(dbg_stall), .dbg_bubble_ex(dbg_bubble_ex),
    .dbg_branch_taken(dbg_branch_taken),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_result(rd_result), .rd_cycle(rd_cycle), .rd_flags(rd_flags),
    .cycle_count(cycle_count), .stall_count(stall_count),
    .bubble_count(bubble_count), .branch_count(branch_count),
    .halted(halted), .timeout(timeout), .overflow(overflow), .done(done)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [31:0] cyc;
    logic [3:0]  flags;
  } rec_t;

  // Reference model: an ideal bounded FIFO of records plus plain counters.
  rec_t   m_q[$];
  longint m_cyc, m_stall, m_bub, m_br, m_max;
  bit     m_halt, m_to, m_ovf;

  typedef struct {
    int          max_c;
    int          halt_at;
    logic [31:0] hinstr;
    bit          exp_halted;
    bit          exp_timeout;
    bit          exp_ovf;
    int          exp_nrec;
    int          exp_first;
    int          exp_cycles;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    longint lim;
    lim = (longint'(1) << CNT_W) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cyc = 0; m_stall = 0; m_bub = 0; m_br = 0;
    m_halt = 0; m_to = 0; m_ovf = 0;
  endtask

  task automatic idle_inputs();
    enable = 0; clear = 0; rd_ready = 0;
    dbg_pc_f = '0; dbg_instr_e = '0; dbg_result_e = '0;
    dbg_stall = 0; dbg_bubble_ex = 0; dbg_branch_taken = 0;
  endtask

  task automatic start_run(input longint mc);
    model_reset();
    m_max = mc;
    max_cycles = mc[CNT_W-1:0];
    enable = 1;
    @(posedge clk); #1;
    enable = 0;
  endtask

  // Drive one RUN cycle and advance the model by the stated rules.
  task automatic run_cycle(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] result, input logic st,
                           input logic bu, input logic br, output bit ended);
    bit   h, wr;
    rec_t r;
    dbg_pc_f = pc; dbg_instr_e = instr; dbg_result_e = result;
    dbg_stall = st; dbg_bubble_ex = bu; dbg_branch_taken = br;
    h  = !bu && (instr == 32'h0000_0073 || instr == 32'h0010_0073);
    wr = 1;
`ifdef TRACE_FILTER_EN
    wr = !(st || bu);
`endif
    if (wr) begin
      r.pc = pc; r.instr = instr; r.result = result;
      r.cyc = m_cyc[31:0]; r.flags = {h, br, bu, st};
      m_q.push_back(r);
      if (m_q.size() > DEPTH) begin
        r = m_q.pop_front();
        m_ovf = 1;
      end
    end
    ended = 0;
    if (h) begin
      m_halt = 1; ended = 1;
    end else if (m_cyc + 1 >= m_max) begin
      m_to = 1; ended = 1;
    end
    m_cyc = sat(m_cyc + 1);
    if (st) m_stall = sat(m_stall + 1);
    if (bu) m_bub = sat(m_bub + 1);
    if (br) m_br = sat(m_br + 1);
    @(posedge clk); #1;
  endtask

  // Pull every modelled record out of the DUT, with random backpressure.
  task automatic drain(input int ready_pct, output int nrec, output longint first_cyc);
    int   guard;
    rec_t r;
    nrec = 0; first_cyc = -1; guard = 0;
    dbg_stall = 0; dbg_bubble_ex = 0; dbg_branch_taken = 0; dbg_instr_e = '0;
    if (m_q.size() == 0) begin
      @(posedge clk); #1;
    end
    while (m_q.size() != 0 && guard < 1000) begin
      rd_ready = ($urandom_range(0, 99) < ready_pct);
      clear    = 1'($urandom_range(0, 1));
      chk("drain_rd_valid",  64'(rd_valid),  64'(1'b1));
      chk("drain_rd_pc",     64'(rd_pc),     64'(m_q[0].pc));
      chk("drain_rd_instr",  64'(rd_instr),  64'(m_q[0].instr));
      chk("drain_rd_result", 64'(rd_result), 64'(m_q[0].result));
      chk("drain_rd_cycle",  64'(rd_cycle),  64'(m_q[0].cyc));
      chk("drain_rd_flags",  64'(rd_flags),  64'(m_q[0].flags));
      @(posedge clk); #1;
      if (rd_ready) begin
        if (nrec == 0) first_cyc = longint'(m_q[0].cyc);
        nrec++;
        r = m_q.pop_front();
      end
      guard++;
    end
    rd_ready = 0; clear = 0;
    if (guard >= 1000) begin
      checks++; failures++;
      $display("FAIL drain_bound actual=%0d required=<1000 cycles", guard);
    end
  endtask

  task automatic check_end();
    chk("end_done",     64'(done),         64'(1'b1));
    chk("end_rd_valid", 64'(rd_valid),     64'(1'b0));
    chk("end_rd_pc",    64'(rd_pc),        64'(0));
    chk("end_halted",   64'(halted),       64'(m_halt));
    chk("end_timeout",  64'(timeout),      64'(m_to));
    chk("end_overflow", 64'(overflow),     64'(m_ovf));
    chk("end_cycles",   64'(cycle_count),  64'(m_cyc));
    chk("end_stalls",   64'(stall_count),  64'(m_stall));
    chk("end_bubbles",  64'(bubble_count), 64'(m_bub));
    chk("end_branches", 64'(branch_count), 64'(m_br));
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    chk("clr_done",     64'(done),        64'(1'b0));
    chk("clr_cycles",   64'(cycle_count), 64'(0));
    chk("clr_stalls",   64'(stall_count), 64'(0));
    chk("clr_halted",   64'(halted),      64'(1'b0));
    chk("clr_timeout",  64'(timeout),     64'(1'b0));
    chk("clr_overflow", 64'(overflow),    64'(1'b0));
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t   tbl[7];
    bit     ended;
    int     nrec;
    longint first;
    logic [31:0] instr, pc0;

    tbl[0] = '{100,  5, 32'h0000_0073, 1, 0, 0,  6,  0,  6};
    tbl[1] = '{ 40, -1, 32'h0000_0013, 0, 1, 1, 16, 24, 40};
    tbl[2] = '{  8,  7, 32'h0010_0073, 1, 0, 0,  8,  0,  8};
    tbl[3] = '{  0, -1, 32'h0000_0013, 0, 1, 0,  1,  0,  1};
    tbl[4] = '{ 16, -1, 32'h0000_0013, 0, 1, 0, 16,  0, 16};
    tbl[5] = '{ 17, -1, 32'h0000_0013, 0, 1, 1, 16,  1, 17};
    tbl[6] = '{100,  0, 32'h0010_0073, 1, 0, 0,  1,  0,  1};

    rst = 1;
    idle_inputs();
    max_cycles = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", 64'(rd_valid),    64'(1'b0));
    chk("rst_done",     64'(done),        64'(1'b0));
    chk("rst_cycles",   64'(cycle_count), 64'(0));
    chk("rst_halted",   64'(halted),      64'(1'b0));
    chk("rst_rd_pc",    64'(rd_pc),       64'(0));
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // Table-driven stop scenarios with a clean instruction stream.
    for (int v = 0; v < 7; v++) begin
      start_run(longint'(tbl[v].max_c));
      ended = 0;
      for (int i = 0; i < 200 && !ended; i++) begin
        instr = (i == tbl[v].halt_at) ? tbl[v].hinstr : 32'h0000_0013;
        run_cycle(32'(32'h1000 + 4 * i), instr, 32'(i * 3), 1'b0, 1'b0, 1'b0, ended);
      end
      chk("tbl_halted",   64'(halted),      64'(tbl[v].exp_halted));
      chk("tbl_timeout",  64'(timeout),     64'(tbl[v].exp_timeout));
      chk("tbl_overflow", 64'(overflow),    64'(tbl[v].exp_ovf));
      chk("tbl_cycles",   64'(cycle_count), 64'(tbl[v].exp_cycles));
      drain(100, nrec, first);
      chk("tbl_nrec",  64'(nrec),  64'(tbl[v].exp_nrec));
      chk("tbl_first", 64'(first), 64'(tbl[v].exp_first));
      check_end();
      do_clear();
    end

    // ECALL inside a bubble must not halt; stall every third cycle.
    start_run(30);
    ended = 0;
    for (int i = 0; i < 40 && !ended; i++) begin
      instr = (i == 4) ? 32'h0000_0073 : 32'h0000_0013;
      run_cycle(32'(32'h2000 + 4 * i), instr, 32'(i), 1'((i % 3) == 0),
                1'(i == 4), 1'((i % 5) == 1), ended);
    end
    chk("seq_stall_count",  64'(stall_count),  64'(10));
    chk("seq_bubble_count", 64'(bubble_count), 64'(1));
    chk("seq_no_halt",      64'(halted),       64'(1'b0));
    chk("seq_timeout",      64'(timeout),      64'(1'b1));
    drain(100, nrec, first);
    check_end();
    do_clear();

    // Backpressure holds the record steady, then async reset mid-drain.
    start_run(100);
    ended = 0;
    for (int i = 0; i < 20 && !ended; i++) begin
      instr = (i == 9) ? 32'h0000_0073 : 32'h0000_0013;
      run_cycle(32'(32'h3000 + 4 * i), instr, 32'(i + 7), 1'b0, 1'b0, 1'b0, ended);
    end
    rd_ready = 0;
    pc0 = m_q[0].pc;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_rd_valid", 64'(rd_valid), 64'(1'b1));
      chk("hold_rd_pc",    64'(rd_pc),    64'(pc0));
      chk("hold_rd_instr", 64'(rd_instr), 64'(m_q[0].instr));
    end
    rd_ready = 1;
    @(posedge clk); #1;
    rd_ready = 0;
    chk("hold_next_pc", 64'(rd_pc), 64'(m_q[1].pc));
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("arst_rd_valid", 64'(rd_valid),    64'(1'b0));
    chk("arst_done",     64'(done),        64'(1'b0));
    chk("arst_cycles",   64'(cycle_count), 64'(0));
    chk("arst_halted",   64'(halted),      64'(1'b0));
    chk("arst_rd_pc",    64'(rd_pc),       64'(0));
    @(negedge clk);
    rst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("arst_idle_cycles", 64'(cycle_count), 64'(0));
    chk("arst_idle_valid",  64'(rd_valid),    64'(1'b0));

`ifdef TRACE_FILTER_EN
    // Filtered build: 10 cycles with 4 stalls, halt on the 11th.
    start_run(100);
    ended = 0;
    for (int i = 0; i < 20 && !ended; i++) begin
      instr = (i == 10) ? 32'h0000_0073 : 32'h0000_0013;
      run_cycle(32'(32'h4000 + 4 * i), instr, 32'(i), 1'(i == 1 || i == 3 || i == 5 || i == 7),
                1'b0, 1'b0, ended);
    end
    chk("filt_stalls", 64'(stall_count), 64'(4));
    drain(100, nrec, first);
    chk("filt_nrec", 64'(nrec), 64'(7));
    check_end();
    do_clear();
`endif

    // Randomized runs; enable and clear toggle where they must be ignored.
    for (int n = 0; n < 8; n++) begin
      start_run(longint'($urandom_range(1, 60)));
      ended = 0;
      for (int i = 0; i < 100 && !ended; i++) begin
        case ($urandom_range(0, 19))
          0:       instr = 32'h0000_0073;
          1:       instr = 32'h0010_0073;
          default: instr = $urandom();
        endcase
        enable = 1'($urandom_range(0, 1));
        clear  = 1'($urandom_range(0, 1));
        run_cycle($urandom(), instr, $urandom(), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ended);
      end
      enable = 0; clear = 0;
      drain(60, nrec, first);
      check_end();
      do_clear();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
